tt_um_lab2_q3_sub: RTL and testbench

Bit-serial 7-bit subtractor tile, the inverse of the lab2_q3 adder tile. It takes a sum and one addend and recovers the other addend: difference = A − B mod 128, where A is the minuend and B the subtrahend. The operation runs LSB-first over 7 clock cycles, with a start/done handshake on the spare MSB pins. It uses the standard TinyTapeout tile wrapper, and the adder and subtractor tiles can be chained on the bench for round-trip checks.

---
 rtl/tt_um_lab2_q3_sub_if.sv | 20 ++
 rtl/tt_um_lab2_q3_sub.sv | 121 ++++++++++++
 tb/tb_tt_um_lab2_q3_sub.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/tt_um_lab2_q3_sub_if.sv
// Pin bundle for the lab2_q3 subtractor tile: the TinyTapeout user pins
// grouped so the bench drives them as master and the tile consumes them as slave.
interface tt_um_lab2_q3_sub_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/tt_um_lab2_q3_sub.sv
// Bit-serial 7-bit subtractor tile: diff = A - B mod 128, processed LSB-first
// over 7 cycles after a rising edge on ui_in[7]; done and borrow on the spare pins.
module tt_um_lab2_q3_sub (
  input logic              clk,
  input logic              rst_n,
  tt_um_lab2_q3_sub_if.slave tt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       start_q;
  logic       start_ev;
  logic       last_bit;
  logic       load_op;
  logic       shift_op;
  logic       done;
  logic [6:0] a_sr;
  logic [6:0] b_sr;
  logic [6:0] res_sr;
  logic [6:0] diff_q;
  logic [2:0] cnt;
  logic       br;
  logic       borrow_q;
  logic [1:0] step;
  logic       unused_ok;

  // One full-subtractor bit slice: returns {borrow_out, difference_bit}.
  function automatic logic [1:0] sub_bit(input logic a0, input logic b0, input logic bin);
    logic d;
    logic bout;
    d    = a0 ^ b0 ^ bin;
    bout = (~a0 & b0) | (~(a0 ^ b0) & bin);
    return {bout, d};
  endfunction

  assign start_ev = tt.ui_in[7] & ~start_q;
  assign last_bit = (cnt == 3'd6);
  assign step     = sub_bit(a_sr[0], b_sr[0], br);

  // ena and uio_in[7] carry no function on this tile.
  assign unused_ok = &{1'b0, tt.ena, tt.uio_in[7]};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: a start event is honoured only outside SHIFT.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ev) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    if (start_ev) state_nxt = SHIFT;
      default: state_nxt = IDLE;
    endcase
  end

  // Output/control decode from the current state.
  always_comb begin
    load_op  = 1'b0;
    shift_op = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:  load_op = start_ev;
      SHIFT: shift_op = 1'b1;
      DONE: begin
        done    = 1'b1;
        load_op = start_ev;
      end
      default: ;
    endcase
  end

  // Start-level history; resets high so a level held through reset is not a start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) start_q <= 1'b1;
    else        start_q <= tt.ui_in[7];
  end

  // Serial datapath: operand load, per-bit subtract, result capture on the 7th bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      diff_q   <= '0;
      cnt      <= '0;
      br       <= 1'b0;
      borrow_q <= 1'b0;
    end else if (load_op) begin
      a_sr   <= tt.ui_in[6:0];
      b_sr   <= tt.uio_in[6:0];
      res_sr <= '0;
      cnt    <= '0;
      br     <= 1'b0;
    end else if (shift_op) begin
      a_sr   <= {1'b0, a_sr[6:1]};
      b_sr   <= {1'b0, b_sr[6:1]};
      res_sr <= {step[0], res_sr[6:1]};
      br     <= step[1];
      cnt    <= cnt + 3'd1;
      if (last_bit) begin
        diff_q   <= {step[0], res_sr[6:1]};
        borrow_q <= step[1];
      end
    end
  end

  assign tt.uo_out  = {done, diff_q};
  assign tt.uio_out = {borrow_q, 7'd0};
  assign tt.uio_oe  = 8'h80;

endmodule

// File: tb/tb_tt_um_lab2_q3_sub.sv
// Scoreboard bench for the bit-serial subtractor tile.
module tb_tt_um_lab2_q3_sub;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  logic [7:0] sb[$];
  logic [6:0] exp_diff;
  logic       exp_brw;
  logic       prev_done;

  tt_um_lab2_q3_sub_if tt ();

  tt_um_lab2_q3_sub dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tt    (tt.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] model(input logic [6:0] a, input logic [6:0] b);
    logic [6:0] d;
    d = a - b;
    return {(b > a), d};
  endfunction

  // Monitor: pop the scoreboard on each done rise; outputs must hold between rises.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tt.uo_out[7] && !prev_done) begin
        check_eq("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          logic [7:0] e;
          e        = sb.pop_front();
          exp_diff = e[6:0];
          exp_brw  = e[7];
        end
      end
      check_eq("diff", {25'd0, tt.uo_out[6:0]}, {25'd0, exp_diff});
      check_eq("borrow", {31'd0, tt.uio_out[7]}, {31'd0, exp_brw});
      check_eq("uio_lo", {25'd0, tt.uio_out[6:0]}, 32'd0);
      check_eq("uio_oe", {24'd0, tt.uio_oe}, 32'h80);
    end
    prev_done = tt.uo_out[7];
  end

  // mode 0: plain; 1: operands zeroed during SHIFT; 2: extra rising edge at SHIFT cycle 3.
  task automatic run_op(input logic [6:0] a, input logic [6:0] b, input int mode);
    int cycles;
    @(negedge clk);
    tt.ui_in  = {1'b0, a};
    tt.uio_in = {1'b0, b};
    @(negedge clk);
    tt.ui_in[7] = 1'b1;
    sb.push_back(model(a, b));
    cycles = 0;
    while (cycles <= 20) begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) begin
        check_eq("done_drop", {31'd0, tt.uo_out[7]}, 32'd0);
        tt.ui_in[7] = 1'b0;
        if (mode == 1) begin
          tt.ui_in[6:0]  = 7'h00;
          tt.uio_in[6:0] = 7'h00;
        end
      end
      if (mode == 2 && cycles == 3) begin
        tt.ui_in  = 8'hFF;
        tt.uio_in = 8'h7E;
      end
      if (mode == 2 && cycles == 4) tt.ui_in[7] = 1'b0;
      if (tt.uo_out[7]) break;
    end
    check_eq("latency", cycles, 32'd8);
  endtask

  // Asynchronous reset asserted between clock edges, start level chosen by caller.
  task automatic reset_mid(input logic start_level);
    @(posedge clk);
    #3;
    rst_n       = 1'b0;
    tt.ui_in[7] = start_level;
    #1;
    check_eq("rst_uo_out", {24'd0, tt.uo_out}, 32'h00);
    check_eq("rst_uio_out", {24'd0, tt.uio_out}, 32'h00);
    check_eq("rst_uio_oe", {24'd0, tt.uio_oe}, 32'h80);
    sb.delete();
    exp_diff = '0;
    exp_brw  = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int hi_cnt;
    logic [6:0] bv;
    n_checks  = 0;
    n_fail    = 0;
    exp_diff  = '0;
    exp_brw   = 1'b0;
    prev_done = 1'b0;
    rst_n     = 1'b0;
    tt.ena    = 1'b1;
    tt.ui_in  = 8'h00;
    tt.uio_in = 8'h00;

    // Reset with start held high across release: no operation may start.
    reset_mid(1'b1);
    hi_cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (tt.uo_out[7]) hi_cnt++;
    end
    check_eq("no_start_after_rst", hi_cnt, 32'd0);

    // Directed arithmetic cases.
    run_op(7'h4B, 7'h19, 0);
    check_eq("uo_4b_19", {24'd0, tt.uo_out}, 32'hB2);
    check_eq("uio_4b_19", {24'd0, tt.uio_out}, 32'h00);
    run_op(7'h4B, 7'h19, 1);
    check_eq("uo_sampled_once", {24'd0, tt.uo_out}, 32'hB2);
    run_op(7'h05, 7'h0A, 0);
    check_eq("uo_05_0a", {24'd0, tt.uo_out}, 32'hFB);
    check_eq("uio_05_0a", {24'd0, tt.uio_out}, 32'h80);
    run_op(7'h7F, 7'h7F, 0);
    check_eq("uo_7f_7f", {24'd0, tt.uo_out}, 32'h80);
    check_eq("uio_7f_7f", {24'd0, tt.uio_out}, 32'h00);
    run_op(7'h7F, 7'd27, 0);
    check_eq("uo_roundtrip", {24'd0, tt.uo_out}, 32'hE4);

    // Second rising edge during SHIFT is ignored.
    run_op(7'h30, 7'h45, 2);
    check_eq("uo_ignored_edge", {24'd0, tt.uo_out}, 32'hEB);
    repeat (3) @(negedge clk);
    check_eq("no_retrigger_done", {31'd0, tt.uo_out[7]}, 32'd1);

    // Start held high for 20 cycles yields exactly one operation.
    @(negedge clk);
    tt.ui_in  = 8'h11;
    tt.uio_in = 8'h22;
    @(negedge clk);
    tt.ui_in[7] = 1'b1;
    sb.push_back(model(7'h11, 7'h22));
    hi_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (tt.uo_out[7]) hi_cnt++;
    end
    check_eq("held_start_one_op", hi_cnt, 32'd13);
    tt.ui_in[7] = 1'b0;

    // Reset from DONE with outputs non-zero.
    reset_mid(1'b0);
    run_op(7'h40, 7'h01, 0);

    // Reset at SHIFT cycle 3, then a clean operation.
    @(negedge clk);
    tt.ui_in  = 8'h2A;
    tt.uio_in = 8'h15;
    @(negedge clk);
    tt.ui_in[7] = 1'b1;
    repeat (3) @(negedge clk);
    tt.ui_in[7] = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check_eq("shift_rst_uo", {24'd0, tt.uo_out}, 32'h00);
    check_eq("shift_rst_uio", {24'd0, tt.uio_out}, 32'h00);
    sb.delete();
    exp_diff = '0;
    exp_brw  = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    run_op(7'h2A, 7'h15, 0);
    check_eq("uo_after_shift_rst", {24'd0, tt.uo_out}, 32'h95);

    // Sweep every A against a spread of B values.
    for (int a = 0; a < 128; a++) begin
      for (int k = 0; k < 5; k++) begin
        case (k)
          0:       bv = 7'h00;
          1:       bv = 7'h01;
          2:       bv = 7'(a);
          3:       bv = 7'h7F;
          default: bv = 7'($urandom_range(0, 127));
        endcase
        run_op(7'(a), bv, 0);
      end
    end

    @(negedge clk);
    check_eq("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
